// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: sweeps every N_IN-bit input vector in ascending
// order, holds each for HOLD cycles and compares the DUT output at the end of the hold.
module truth_table_checker #(
  parameter int                  N_IN   = 4,
  parameter logic [2**N_IN-1:0]  EXPECT = 16'h6996,
  parameter int                  HOLD   = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic [N_IN-1:0]   vec,
  input  logic              dut_o,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic [N_IN-1:0]   first_err_vec,
  output logic              first_err_valid
);

  // state | meaning
  // IDLE  | waiting for start after reset, outputs cleared
  // RUN   | sweeping vectors, busy high
  // DONE  | sweep finished, results held until start or reset

  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [N_IN:0]   ERR_MAX   = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [HW-1:0]   hold_q;
  logic [N_IN-1:0] vec_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] first_vec_q;
  logic            first_valid_q;

  logic start_sweep;
  logic sample;
  logic last_vec;
  logic mismatch;

  assign start_sweep = (state_q != S_RUN) && start;
  assign sample      = (state_q == S_RUN) && (hold_q == HOLD_LAST);
  assign last_vec    = (vec_q == VEC_LAST);
  assign mismatch    = (dut_o != EXPECT[vec_q]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (sample && last_vec) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    pass = done && (err_q == '0);
  end

  // The compare result lands in the same edge that advances vec or ends the sweep.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q        <= '0;
      vec_q         <= '0;
      err_q         <= '0;
      first_vec_q   <= '0;
      first_valid_q <= 1'b0;
    end else if (start_sweep) begin
      hold_q        <= '0;
      vec_q         <= '0;
      err_q         <= '0;
      first_vec_q   <= '0;
      first_valid_q <= 1'b0;
    end else if (sample) begin
      if (mismatch) begin
        if (err_q != ERR_MAX) begin
          err_q <= err_q + (N_IN+1)'(1);
        end
        if (!first_valid_q) begin
          first_vec_q   <= vec_q;
          first_valid_q <= 1'b1;
        end
      end
      if (!last_vec) begin
        vec_q  <= vec_q + N_IN'(1);
        hold_q <= '0;
      end
    end else if (state_q == S_RUN) begin
      hold_q <= hold_q + HW'(1);
    end
  end

  assign vec             = vec_q;
  assign err_cnt         = err_q;
  assign first_err_vec   = first_vec_q;
  assign first_err_valid = first_valid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a default 4-input XOR instance with injectable faults
// and a 2-input AND instance with HOLD = 1.
module tb_truth_table_checker;

  localparam int HOLD_M  = 5;
  localparam int NVEC_M  = 16;
  localparam int SWEEP_M = HOLD_M * NVEC_M;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic        start = 1'b0;
  logic [3:0]  vec;
  logic        dut_o;
  logic        busy, done, pass;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_vec;
  logic        first_err_valid;
  logic [15:0] fault_mask = '0;

  logic        start2 = 1'b0;
  logic [1:0]  vec2;
  logic        dut_o2;
  logic        busy2, done2, pass2;
  logic [2:0]  err_cnt2;
  logic [1:0]  first_err_vec2;
  logic        first_err_valid2;
  logic [3:0]  fault_mask2 = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // Lab DUTs: XOR / AND reference gates with per-vector output inversion.
  always_comb dut_o  = (^vec) ^ fault_mask[vec];
  always_comb dut_o2 = (&vec2) ^ fault_mask2[vec2];

  truth_table_checker u_dut (
    .clk(clk), .rstn(rstn), .start(start), .vec(vec), .dut_o(dut_o),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );

  truth_table_checker #(.N_IN(2), .EXPECT(4'b1000), .HOLD(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .vec(vec2), .dut_o(dut_o2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .first_err_vec(first_err_vec2), .first_err_valid(first_err_valid2)
  );

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          pulse_at;
    int          exp_err;
    int          exp_first;
    bit          exp_valid;
  } case_t;

  case_t cases[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: every inverted vector is one error; the lowest one is captured first.
  task automatic model(input logic [15:0] mask, output int e, output int f, output bit v);
    e = 0; f = 0; v = 0;
    for (int i = 0; i < NVEC_M; i++) begin
      if (mask[i]) begin
        if (!v) f = i;
        v = 1;
        e++;
      end
    end
  endtask

  task automatic run_main(input string name, input logic [15:0] mask, input int pulse_at,
                          input int e, input int f, input bit v);
    int bad = 0;
    fault_mask = mask;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < SWEEP_M; c++) begin
      if (vec !== 4'(c / HOLD_M) || busy !== 1'b1 || done !== 1'b0) bad++;
      start = (c == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_steps"}, bad, 0);
    check({name, "_done"}, done, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_vec_last"}, vec, 15);
    check({name, "_err_cnt"}, err_cnt, e);
    check({name, "_first_vec"}, first_err_vec, f);
    check({name, "_first_valid"}, first_err_valid, v);
    check({name, "_pass"}, pass, (e == 0));
  endtask

  task automatic run_small(input string name, input logic [3:0] mask, input int e, input int f);
    int bad = 0;
    fault_mask2 = mask;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (vec2 !== 2'(c) || busy2 !== 1'b1 || done2 !== 1'b0) bad++;
      @(negedge clk);
    end
    check({name, "_steps"}, bad, 0);
    check({name, "_done"}, done2, 1);
    check({name, "_err_cnt"}, err_cnt2, e);
    check({name, "_first_vec"}, first_err_vec2, f);
    check({name, "_first_valid"}, first_err_valid2, (e != 0));
    check({name, "_pass"}, pass2, (e == 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e, f;
    bit v;
    logic [15:0] m;

    cases[0] = '{"xor_clean",   16'h0000, -1,  0,  0, 0};
    cases[1] = '{"xor_bad3",    16'h0008, -1,  1,  3, 1};
    cases[2] = '{"stuck0",      16'h6996, -1,  8,  1, 1};
    cases[3] = '{"bad_last",    16'h8000, -1,  1, 15, 1};
    cases[4] = '{"all_bad",     16'hFFFF, -1, 16,  0, 1};
    cases[5] = '{"start_mid",   16'h0008, 20,  1,  3, 1};

    repeat (3) @(negedge clk);
    check("rst_vec", vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_first_vec", first_err_vec, 0);
    check("rst_first_valid", first_err_valid, 0);
    check("rst_busy2", busy2, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    foreach (cases[i])
      run_main(cases[i].name, cases[i].mask, cases[i].pulse_at,
               cases[i].exp_err, cases[i].exp_first, cases[i].exp_valid);

    // start held into DONE restarts immediately and clears the previous result
    start = 1'b1;
    fault_mask = '0;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_err", err_cnt, 0);
    check("restart_valid", first_err_valid, 0);
    check("restart_vec", vec, 0);
    repeat (SWEEP_M) @(negedge clk);
    check("restart_final_pass", pass, 1);

    // reset in the middle of a sweep that already has an error recorded
    fault_mask = 16'h0008;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_err_before", err_cnt, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_vec", vec, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_cnt, 0);
    check("mid_rst_valid", first_err_valid, 0);
    check("mid_rst_first", first_err_vec, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_done", done, 0);
    check("post_rst_idle_vec", vec, 0);
    run_main("after_rst", 16'h0000, -1, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      m = 16'($urandom);
      if (r == 0) m = m & 16'h00F0;
      model(m, e, f, v);
      run_main($sformatf("rand%0d", r), m, -1, e, f, v);
    end

    run_small("and_clean", 4'b0000, 0, 0);
    run_small("and_bad_last", 4'b1000, 1, 3);
    run_small("and_bad_01", 4'b0011, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
